// File: rtl/keypad_pkg.sv
// Shared key codes, lock states and key classification for the keypad code lock.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_PROG  = 4'hC;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT,
    PROGRAM
  } lock_state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_event_detect.sv
// Turns the scanner's digit pair into one-cycle key events and its slowtimer into ticks.
module keypad_event_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] current_digit,
  input  logic [3:0] last_digit,
  input  logic       slowtimer,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       tick
);

  logic [7:0] pair_q, pair_d;
  logic       primed_q, primed_d;
  logic       valid_q, valid_d;
  logic [3:0] code_q, code_d;
  logic       slow_q, slow_d;

  // The first edge after reset only loads the pair, so a stale key is never replayed.
  always_comb begin
    pair_d   = {current_digit, last_digit};
    primed_d = 1'b1;
    valid_d  = primed_q && (pair_d != pair_q);
    code_d   = current_digit;
    slow_d   = slowtimer;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q   <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      code_q   <= '0;
      slow_q   <= 1'b0;
    end else begin
      pair_q   <= pair_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      slow_q   <= slow_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign tick      = primed_q && slowtimer && !slow_q;

endmodule

// File: rtl/keypad_code_lock.sv
// Combination-lock controller fed by keypad scanner events.
// Define KEYPAD_CODE_PROGRAM_EN to allow reprogramming the code from the open window.
module keypad_code_lock
  import keypad_pkg::*;
#(
  parameter int                  DIGITS        = 4,
  parameter int                  MAX_TRIES     = 3,
  parameter int                  OPEN_TICKS    = 8,
  parameter int                  LOCKOUT_TICKS = 16,
  parameter logic [DIGITS*4-1:0] RESET_CODE    = 16'h1234
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic [3:0] currentDigit,
  input  logic [3:0] lastDigit,
  input  logic       slowtimer,
  output logic       unlocked,
  output logic       locked_out,
  output logic       bad_code,
  output logic [3:0] entry_count,
  output logic       key_event
);

  localparam int BW        = DIGITS * 4;
  localparam int MAX_TICKS = (OPEN_TICKS > LOCKOUT_TICKS) ? OPEN_TICKS : LOCKOUT_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam int FW        = $clog2(MAX_TRIES + 1);

  localparam logic [3:0]    FULL   = 4'(DIGITS);
  localparam logic [TW-1:0] OPEN_T = TW'(OPEN_TICKS);
  localparam logic [TW-1:0] LOCK_T = TW'(LOCKOUT_TICKS);
  localparam logic [TW-1:0] SAT_T  = TW'(MAX_TICKS);
  localparam logic [FW-1:0] TRIES  = FW'(MAX_TRIES);

  logic          key_valid;
  logic [3:0]    key_code;
  logic          tick;

  lock_state_e   state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    count_q, count_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          unlocked_q, unlocked_d;
  logic          locked_out_q, locked_out_d;
  logic          bad_code_q, bad_code_d;
  logic          key_event_q, key_event_d;
  logic [TW-1:0] tcnt_inc;
  logic          open_done, lock_done;
  logic [BW-1:0] code;

`ifdef KEYPAD_CODE_PROGRAM_EN
  logic [BW-1:0] code_q, code_d;
  assign code = code_q;
`else
  assign code = RESET_CODE;
`endif

  keypad_event_detect u_event_detect (
    .clk          (ph1),
    .rst_n        (reset),
    .current_digit(currentDigit),
    .last_digit   (lastDigit),
    .slowtimer    (slowtimer),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .tick         (tick)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    count_d     = count_q;
    fail_d      = fail_q;
    tcnt_d      = tcnt_q;
    bad_code_d  = 1'b0;
    key_event_d = key_valid;
`ifdef KEYPAD_CODE_PROGRAM_EN
    code_d      = code_q;
`endif
    tcnt_inc    = tcnt_q + TW'(1);
    open_done   = tick && (tcnt_inc == OPEN_T);
    lock_done   = tick && (tcnt_inc == LOCK_T);
    if (tick && (tcnt_q != SAT_T)) tcnt_d = tcnt_inc;

    case (state_q)
      ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            buf_d = {buf_q[BW-5:0], key_code};
            if (count_q < FULL) count_d = count_q + 4'd1;
          end else if (key_code == KEY_CLEAR) begin
            buf_d   = '0;
            count_d = '0;
          end else if (key_code == KEY_ENTER) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        buf_d   = '0;
        count_d = '0;
        if ((count_q == FULL) && (buf_q == code)) begin
          fail_d  = '0;
          state_d = OPEN;
        end else begin
          bad_code_d = 1'b1;
          fail_d     = fail_q + FW'(1);
          state_d    = (fail_d == TRIES) ? LOCKOUT : ENTRY;
        end
      end
      OPEN: begin
        if (open_done || (key_valid && (key_code == KEY_CLEAR))) begin
          state_d = ENTRY;
`ifdef KEYPAD_CODE_PROGRAM_EN
        end else if (key_valid && (key_code == KEY_PROG)) begin
          state_d = PROGRAM;
`endif
        end
      end
      LOCKOUT: begin
        if (lock_done) begin
          fail_d  = '0;
          state_d = ENTRY;
        end
      end
`ifdef KEYPAD_CODE_PROGRAM_EN
      // New digits beyond a full buffer are ignored; only a full buffer can be committed.
      PROGRAM: begin
        if (open_done || (key_valid && (key_code == KEY_CLEAR))) begin
          buf_d   = '0;
          count_d = '0;
          state_d = ENTRY;
        end else if (key_valid) begin
          if (is_digit(key_code) && (count_q < FULL)) begin
            buf_d   = {buf_q[BW-5:0], key_code};
            count_d = count_q + 4'd1;
          end else if ((key_code == KEY_ENTER) && (count_q == FULL)) begin
            code_d  = buf_q;
            buf_d   = '0;
            count_d = '0;
            state_d = ENTRY;
          end
        end
      end
`endif
      default: state_d = ENTRY;
    endcase

    if (state_d != state_q) tcnt_d = '0;
    unlocked_d   = (state_d == OPEN) || (state_d == PROGRAM);
    locked_out_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q      <= ENTRY;
      buf_q        <= '0;
      count_q      <= '0;
      fail_q       <= '0;
      tcnt_q       <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      bad_code_q   <= 1'b0;
      key_event_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      fail_q       <= fail_d;
      tcnt_q       <= tcnt_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      bad_code_q   <= bad_code_d;
      key_event_q  <= key_event_d;
    end
  end

`ifdef KEYPAD_CODE_PROGRAM_EN
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) code_q <= RESET_CODE;
    else        code_q <= code_d;
  end
`endif

  assign unlocked    = unlocked_q;
  assign locked_out  = locked_out_q;
  assign bad_code    = bad_code_q;
  assign entry_count = count_q;
  assign key_event   = key_event_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Self-checking bench for keypad_code_lock: directed scenarios plus random keys and ticks
// compared against a digit-queue reference model.
module tb_keypad_code_lock;

   logic       ph1 = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] currentDigit = 4'h0;
   logic [3:0] lastDigit = 4'h0;
   logic       slowtimer = 1'b0;
   logic       unlocked;
   logic       locked_out;
   logic       bad_code;
   logic [3:0] entry_count;
   logic       key_event;

   keypad_code_lock dut (
      .ph1         (ph1),
      .reset       (reset),
      .currentDigit(currentDigit),
      .lastDigit   (lastDigit),
      .slowtimer   (slowtimer),
      .unlocked    (unlocked),
      .locked_out  (locked_out),
      .bad_code    (bad_code),
      .entry_count (entry_count),
      .key_event   (key_event)
   );

   always #5 ph1 = ~ph1;

   int checks = 0;
   int passes = 0;
   int obsKeyEvents = 0;
   int obsBad = 0;

   // Reference model: entered digits as a queue, open/lockout as remaining-tick budgets.
   int          mDigits[$];
   int          mProg[$];
   int          mFails;
   bit          mOpen, mLocked, mProgram;
   int          mTicksLeft;
   logic [15:0] mCode = 16'h1234;
   int          expKeyEvents = 0;
   int          expBad = 0;

   // Pulses last one cycle, so counting on the falling edge sees each exactly once.
   always @(negedge ph1) begin
      if (reset === 1'b1) begin
         if (key_event === 1'b1) obsKeyEvents++;
         if (bad_code === 1'b1) obsBad++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   function automatic logic [15:0] packDigits(input int q[$]);
      logic [15:0] v = '0;
      foreach (q[i]) v = {v[11:0], 4'(q[i])};
      return v;
   endfunction

   function automatic void modelReset();
      mDigits.delete();
      mProg.delete();
      mFails = 0;
      mOpen = 0;
      mLocked = 0;
      mProgram = 0;
      mTicksLeft = 0;
      mCode = 16'h1234;
   endfunction

   function automatic void modelKey(input int k);
      expKeyEvents++;
      if (mLocked) return;
      if (mProgram) begin
         if (k == 10) begin
            mProgram = 0; mOpen = 0; mProg.delete();
         end else if (k <= 9) begin
            if (mProg.size() < 4) mProg.push_back(k);
         end else if (k == 11 && mProg.size() == 4) begin
            mCode = packDigits(mProg);
            mProgram = 0; mOpen = 0; mProg.delete();
         end
         return;
      end
      if (mOpen) begin
         if (k == 10) mOpen = 0;
`ifdef KEYPAD_CODE_PROGRAM_EN
         else if (k == 12) begin
            mProgram = 1; mTicksLeft = 8; mProg.delete();
         end
`endif
         return;
      end
      if (k <= 9) begin
         mDigits.push_back(k);
         if (mDigits.size() > 4) void'(mDigits.pop_front());
      end else if (k == 10) begin
         mDigits.delete();
      end else if (k == 11) begin
         if (mDigits.size() == 4 && packDigits(mDigits) == mCode) begin
            mFails = 0; mOpen = 1; mTicksLeft = 8;
         end else begin
            expBad++;
            mFails++;
            if (mFails == 3) begin
               mLocked = 1; mTicksLeft = 16;
            end
         end
         mDigits.delete();
      end
   endfunction

   function automatic void modelTick();
      if (mOpen || mLocked) begin
         mTicksLeft--;
         if (mTicksLeft == 0) begin
            if (mLocked) mFails = 0;
            mOpen = 0; mLocked = 0; mProgram = 0; mProg.delete();
         end
      end
   endfunction

   function automatic int expCount();
      if (mProgram) return mProg.size();
      if (mOpen || mLocked) return 0;
      return mDigits.size();
   endfunction

   task automatic checkAll(input string tag);
      checkOutput({tag, "/unlocked"}, 32'(unlocked), 32'(mOpen));
      checkOutput({tag, "/locked_out"}, 32'(locked_out), 32'(mLocked));
      checkOutput({tag, "/entry_count"}, 32'(entry_count), 32'(expCount()));
      checkOutput({tag, "/key_events"}, 32'(obsKeyEvents), 32'(expKeyEvents));
      checkOutput({tag, "/bad_codes"}, 32'(obsBad), 32'(expBad));
   endtask

   // Present key k as a fresh scanner pair (always differs from the previous pair).
   task automatic driveKey(input logic [3:0] k);
      logic [3:0] nl;
      nl = currentDigit;
      if ({k, nl} == {currentDigit, lastDigit}) nl = lastDigit + 4'd1;
      currentDigit = k;
      lastDigit = nl;
   endtask

   task automatic applyStimulus(input logic [3:0] k, input bit withTick);
      @(negedge ph1);
      driveKey(k);
      if (withTick) begin
         @(negedge ph1);
         slowtimer = 1'b1;
         repeat (2) @(negedge ph1);
         slowtimer = 1'b0;
      end
      repeat (4) @(negedge ph1);
      modelKey(int'(k));
      if (withTick) modelTick();
      checkAll(withTick ? "keyTick" : "key");
   endtask

   task automatic pulseTick();
      @(negedge ph1);
      slowtimer = 1'b1;
      repeat (2) @(negedge ph1);
      slowtimer = 1'b0;
      repeat (2) @(negedge ph1);
      modelTick();
      checkAll("tick");
   endtask

   task automatic enterCode(input logic [15:0] v);
      for (int d = 3; d >= 0; d--) applyStimulus(v[d*4 +: 4], 1'b0);
      applyStimulus(4'hB, 1'b0);
   endtask

   task automatic doReset();
      @(negedge ph1);
      #2 reset = 1'b0;
      #1;
      modelReset();
      checkOutput("asyncReset/unlocked", 32'(unlocked), 32'd0);
      checkOutput("asyncReset/locked_out", 32'(locked_out), 32'd0);
      checkOutput("asyncReset/entry_count", 32'(entry_count), 32'd0);
      repeat (2) @(negedge ph1);
      reset = 1'b1;
      repeat (3) @(negedge ph1);
      checkAll("afterReset");
   endtask

   initial begin
      #1 reset = 1'b0;
      modelReset();
      repeat (3) @(negedge ph1);
      currentDigit = 4'h7;
      lastDigit = 4'h3;
      reset = 1'b1;
      repeat (3) @(negedge ph1);
      checkAll("reset");
      checkOutput("reset/bad_code", 32'(bad_code), 32'd0);
      checkOutput("reset/key_event", 32'(key_event), 32'd0);

      // First key: event and count appear two edges after the pair changes.
      @(negedge ph1);
      driveKey(4'h1);
      @(negedge ph1);
      checkOutput("lat1/key_event", 32'(key_event), 32'd0);
      @(negedge ph1);
      checkOutput("lat2/key_event", 32'(key_event), 32'd1);
      checkOutput("lat2/entry_count", 32'(entry_count), 32'd1);
      @(negedge ph1);
      checkOutput("lat3/key_event", 32'(key_event), 32'd0);
      modelKey(1);
      checkAll("key1");
      applyStimulus(4'h2, 1'b0);
      applyStimulus(4'h3, 1'b0);
      applyStimulus(4'h4, 1'b0);

      // ENTER: one cycle in the compare step, then unlocked rises.
      @(negedge ph1);
      driveKey(4'hB);
      repeat (2) @(negedge ph1);
      checkOutput("enter/key_event", 32'(key_event), 32'd1);
      checkOutput("enter/unlockedEarly", 32'(unlocked), 32'd0);
      @(negedge ph1);
      checkOutput("enter/unlocked", 32'(unlocked), 32'd1);
      modelKey(11);
      repeat (2) @(negedge ph1);
      checkAll("enter");
      repeat (8) pulseTick();

      // Three wrong codes, ignored keys during lockout, then recovery.
      repeat (3) enterCode(16'h1235);
      applyStimulus(4'h1, 1'b0);
      applyStimulus(4'hB, 1'b0);
      repeat (16) pulseTick();
      enterCode(16'h1234);
      applyStimulus(4'hA, 1'b0);

      // Five digits saturate the buffer; a key coinciding with a tick while open.
      applyStimulus(4'h9, 1'b0);
      enterCode(16'h1234);
      applyStimulus(4'h5, 1'b1);
      applyStimulus(4'hA, 1'b0);

      // CLEAR mid-entry leaves too few digits.
      applyStimulus(4'h1, 1'b0);
      applyStimulus(4'h2, 1'b0);
      applyStimulus(4'hA, 1'b0);
      applyStimulus(4'h3, 1'b0);
      applyStimulus(4'h4, 1'b0);
      applyStimulus(4'hB, 1'b0);

      // Asynchronous reset while open, mid-entry and in lockout.
      enterCode(16'h1234);
      doReset();
      applyStimulus(4'h1, 1'b0);
      applyStimulus(4'h2, 1'b0);
      doReset();
      repeat (3) applyStimulus(4'hB, 1'b0);
      doReset();

`ifdef KEYPAD_CODE_PROGRAM_EN
      enterCode(16'h1234);
      applyStimulus(4'hC, 1'b0);
      enterCode(16'h5678);
      enterCode(16'h1234);
      enterCode(16'h5678);
      applyStimulus(4'hA, 1'b0);
`endif

      for (int i = 0; i < 160; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 3) pulseTick();
         else if (r == 3) enterCode(mCode);
         else if (r == 4) enterCode(16'($urandom));
         else applyStimulus(4'($urandom_range(0, 15)), 1'b0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
